sequence_generator: RTL

Serial pattern transmitter, the driving end of the single-bit `Binary_In` stream consumed by the team's sequence detectors. It accepts a parallel pattern word, length and repeat count through a valid/ready handshake. It then shifts the pattern out MSB-first, one bit per clock, on `Binary_Out` with a qualifying strobe, and pulses `Done` when finished. Its typical use is as a stimulus source looped back into a detector, or as the transmit side of a serial test link.

---
 rtl/seq_pkg.sv | 15 +
 rtl/pattern_shift_reg.sv | 54 +++++
 rtl/sequence_generator.sv | 101 ++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the serial sequence generator and detector.
// The FSM state encoding and the idle line level live here so both ends of the link agree.
package seq_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } seq_state_t;

    localparam logic IDLE_LEVEL = 1'b1;

endpackage : seq_pkg

// File: rtl/pattern_shift_reg.sv
// Captured pattern word plus a down-counting bit index; presents the bit at the
// current index and flags when the index has reached bit 0.
module pattern_shift_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] pattern_i,
    input  logic [CNT_W-1:0] len_i,
    input  logic             advance_i,
    input  logic             reload_i,
    output logic             bit_o,
    output logic             last_bit_o
);

    logic [WIDTH-1:0] pattern_q, pattern_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] idx_q, idx_d;

    // Next-state: load has priority, then pass reload, then single-step advance.
    always_comb begin
        pattern_d = pattern_q;
        len_d     = len_q;
        idx_d     = idx_q;
        if (load_i) begin
            pattern_d = pattern_i;
            len_d     = len_i;
            idx_d     = (len_i != '0) ? CNT_W'(len_i - CNT_W'(1)) : '0;
        end else if (reload_i) begin
            idx_d     = (len_q != '0) ? CNT_W'(len_q - CNT_W'(1)) : '0;
        end else if (advance_i && (idx_q != '0)) begin
            idx_d     = CNT_W'(idx_q - CNT_W'(1));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pattern_q <= '0;
            len_q     <= '0;
            idx_q     <= '0;
        end else begin
            pattern_q <= pattern_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
        end
    end

    // Mask-and-reduce keeps the select width-agnostic with respect to CNT_W.
    assign bit_o      = |(pattern_q & (WIDTH'(1) << idx_q));
    assign last_bit_o = (idx_q == '0);

endmodule : pattern_shift_reg

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: accepts pattern/length/repeat over valid/ready and
// shifts the pattern out MSB-first with a bit strobe, then pulses Done.
module sequence_generator
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1),
    parameter int unsigned REP_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] Pattern_In,
    input  logic [CNT_W-1:0] Length_In,
    input  logic [REP_W-1:0] Repeat_In,
    input  logic             Start_Valid,
    output logic             Start_Ready,
    output logic             Binary_Out,
    output logic             Bit_Valid,
    output logic             Done
);

    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(WIDTH);

    seq_state_t       state_q, state_d;
    logic [REP_W-1:0] pass_q, pass_d;

    logic [CNT_W-1:0] len_clamped;
    logic             accept;
    logic             sr_load, sr_advance, sr_reload;
    logic             sr_bit, sr_last;

    assign len_clamped = (Length_In > MAX_LEN) ? MAX_LEN : Length_In;
    assign accept      = Start_Valid && (state_q == ST_IDLE);

    pattern_shift_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_shift (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (sr_load),
        .pattern_i  (Pattern_In),
        .len_i      (len_clamped),
        .advance_i  (sr_advance),
        .reload_i   (sr_reload),
        .bit_o      (sr_bit),
        .last_bit_o (sr_last)
    );

    // Next-state and shift-register control.
    always_comb begin
        state_d    = state_q;
        pass_d     = pass_q;
        sr_load    = 1'b0;
        sr_advance = 1'b0;
        sr_reload  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sr_load = 1'b1;
                    pass_d  = Repeat_In;
                    state_d = (len_clamped == '0) ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (!sr_last) begin
                    sr_advance = 1'b1;
                end else if (pass_q != '0) begin
                    // Back-to-back passes: reload the index with no idle gap.
                    sr_reload = 1'b1;
                    pass_d    = REP_W'(pass_q - REP_W'(1));
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            pass_q  <= '0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
        end
    end

    // Moore outputs decoded purely from registered state and shift data.
    assign Start_Ready = (state_q == ST_IDLE);
    assign Bit_Valid   = (state_q == ST_SHIFT);
    assign Done        = (state_q == ST_DONE);
    assign Binary_Out  = (state_q == ST_SHIFT) ? sr_bit : IDLE_LEVEL;

endmodule : sequence_generator
